// File: rtl/apb_pkg.sv
// Shared definitions for the APB memory controller: FSM state encoding and
// default bus/memory geometry.
package apb_pkg;

    localparam int APB_DATA_WIDTH = 32;
    localparam int APB_MEM_WIDTH  = 8;
    localparam int APB_MEM_SIZE   = 256;
    localparam int APB_ADDR_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ACC  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_RD_DONE = 3'd3,
        ST_ERR     = 3'd4
    } apb_state_e;

endpackage

// File: rtl/apb_mem_ctrl.sv
// APB slave bridging to a byte-lane memory with one-cycle read latency.
// Writes complete with zero wait states, reads with one wait state.
module apb_mem_ctrl
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH = APB_DATA_WIDTH,
    parameter int MEM_WIDTH  = APB_MEM_WIDTH,
    parameter int MEM_DEPTH  = DATA_WIDTH / MEM_WIDTH,
    parameter int MEM_SIZE   = APB_MEM_SIZE,
    parameter int ADDR_WIDTH = APB_ADDR_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        psel,
    input  logic                        penable,
    input  logic                        pwrite,
    input  logic [ADDR_WIDTH-1:0]       paddr,
    input  logic [DATA_WIDTH-1:0]       pwdata,
    input  logic [MEM_DEPTH-1:0]        pstrb,
    output logic                        pready,
    output logic [DATA_WIDTH-1:0]       prdata,
    output logic                        pslverr,
    output logic                        mem_wr,
    output logic                        mem_rd,
    output logic [MEM_DEPTH-1:0]        mem_be,
    output logic [$clog2(MEM_SIZE)-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]       mem_data_in,
    input  logic [DATA_WIDTH-1:0]       mem_data_out
);

    localparam int AW = $clog2(MEM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] MEM_SIZE_A = ADDR_WIDTH'(MEM_SIZE);

    apb_state_e            state_q, state_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic                  mem_wr_q, mem_wr_d;
    logic                  mem_rd_q, mem_rd_d;
    logic [MEM_DEPTH-1:0]  mem_be_q, mem_be_d;
    logic [AW-1:0]         mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0] mem_data_in_q, mem_data_in_d;

    logic setup_s;
    logic addr_ok_s;

    assign setup_s   = psel && !penable;
    assign addr_ok_s = (paddr[1:0] == 2'b00) && ((paddr >> 2) < MEM_SIZE_A);

    // Next-state and next-output decode; memory strobes are one-cycle pulses.
    always_comb begin
        state_d       = state_q;
        pready_d      = 1'b0;
        pslverr_d     = 1'b0;
        mem_wr_d      = 1'b0;
        mem_rd_d      = 1'b0;
        mem_be_d      = {MEM_DEPTH{1'b0}};
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        case (state_q)
            ST_IDLE: begin
                if (setup_s) begin
                    mem_address_d = paddr[AW+1:2];
                    if (!addr_ok_s) begin
                        state_d   = ST_ERR;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                    end else if (pwrite) begin
                        state_d       = ST_WR_ACC;
                        pready_d      = 1'b1;
                        mem_wr_d      = 1'b1;
                        mem_be_d      = pstrb;
                        mem_data_in_d = pwdata;
                    end else begin
                        state_d  = ST_RD_WAIT;
                        mem_rd_d = 1'b1;
                        mem_be_d = {MEM_DEPTH{1'b1}};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                // A master that drops psel mid-read gets no completion.
                if (psel) begin
                    state_d  = ST_RD_DONE;
                    pready_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_ACC:  state_d = ST_IDLE;
            ST_RD_DONE: state_d = ST_IDLE;
            ST_ERR:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pready_q      <= 1'b0;
            pslverr_q     <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_rd_q      <= 1'b0;
            mem_be_q      <= {MEM_DEPTH{1'b0}};
            mem_address_q <= {AW{1'b0}};
            mem_data_in_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q       <= state_d;
            pready_q      <= pready_d;
            pslverr_q     <= pslverr_d;
            mem_wr_q      <= mem_wr_d;
            mem_rd_q      <= mem_rd_d;
            mem_be_q      <= mem_be_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
        end
    end

    assign pready      = pready_q;
    assign pslverr     = pslverr_q;
    assign mem_wr      = mem_wr_q;
    assign mem_rd      = mem_rd_q;
    assign mem_be      = mem_be_q;
    assign mem_address = mem_address_q;
    assign mem_data_in = mem_data_in_q;

    // Memory data arrives a cycle after mem_rd, so it is passed straight through in RD_DONE.
    assign prdata = (state_q == ST_RD_DONE) ? mem_data_out : {DATA_WIDTH{1'b0}};

endmodule

// File: doc/apb_mem_ctrl.md
APB_MEM_CTRL -- requirements
Module: apb_mem_ctrl

Interface
REQ-001 The block SHALL have a single clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
REQ-002 The block SHALL take these parameters (name, default, meaning):
  - DATA_WIDTH, 32: APB data width.
  - MEM_WIDTH, 8: byte-lane width.
  - MEM_DEPTH, DATA_WIDTH/MEM_WIDTH: number of lanes.
  - MEM_SIZE, 256: words per lane.
  - ADDR_WIDTH, 32: PADDR width.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
  - clk  in  1  clock.
  - rst  in  1  async active-high reset.
  - psel  in  1  APB select.
  - penable  in  1  APB access phase.
  - pwrite  in  1  1 = write.
  - paddr  in  ADDR_WIDTH  byte address.
  - pwdata  in  DATA_WIDTH  write data.
  - pstrb  in  MEM_DEPTH  write byte strobes.
  - pready  out  1  transfer complete.
  - prdata  out  DATA_WIDTH  read data.
  - pslverr  out  1  transfer error.
  - mem_wr  out  1  memory write enable.
  - mem_rd  out  1  memory read enable.
  - mem_be  out  MEM_DEPTH  lane enables.
  - mem_address  out  $clog2(MEM_SIZE)  word index.
  - mem_data_in  out  DATA_WIDTH  write data to memory.
  - mem_data_out  in  DATA_WIDTH  memory read data, registered one cycle after mem_rd.

Function
REQ-004 The block SHALL implement an FSM with states IDLE, WR_ACC, RD_WAIT, RD_DONE and ERR.
REQ-005 In IDLE, psel=1 with penable=0 (setup cycle T0) SHALL be decoded and registered into the next state at the T0 clock edge.
REQ-006 The address SHALL be valid iff paddr[1:0]==0 and paddr>>2 < MEM_SIZE; mem_address SHALL equal paddr>>2, truncated.
REQ-007 Valid write: the FSM SHALL go to WR_ACC; in T1, mem_wr=1, mem_be=pstrb, mem_data_in=pwdata and pready=1 (zero wait states); the FSM SHALL then return to IDLE.
REQ-008 Valid read: the FSM SHALL go to RD_WAIT; in T1, mem_rd=1, mem_be=all ones and pready=0; in T2 (RD_DONE), pready=1 and prdata=mem_data_out; the FSM SHALL then return to IDLE.
REQ-009 Invalid address: the FSM SHALL go to ERR; in T1, pready=1, pslverr=1, prdata=0, and mem_wr, mem_rd and mem_be SHALL be 0.
REQ-010 A write with pstrb=0 SHALL complete normally, with mem_wr=1 and mem_be=0 (no bytes change).
REQ-011 mem_wr and mem_rd SHALL never be asserted in the same cycle, and each SHALL be asserted for exactly one cycle per transfer.
REQ-012 prdata SHALL be 0 whenever the state is not RD_DONE; pslverr SHALL be 0 whenever the state is not ERR.
REQ-013 Back-to-back transfers: a new setup cycle immediately following the pready=1 cycle SHALL be accepted with no idle cycle.
REQ-014 psel dropping while in RD_WAIT (protocol violation) SHALL return the FSM to IDLE next cycle without asserting pready.
REQ-015 penable=1 seen in IDLE without a preceding setup cycle SHALL be ignored.

Reset
REQ-016 While rst=1, the state SHALL be IDLE and all outputs SHALL be 0, asynchronously.
REQ-017 Reset asserted mid-transfer SHALL abort it with no memory access; the first setup cycle after deassertion SHALL be served normally.

Structure
REQ-018 A shared package apb_pkg SHALL hold the FSM state enum and the default width/size constants.
REQ-019 The address-valid check SHALL be combinational within the module; no sub-module SHALL be used.
REQ-020 mem_wr, mem_rd, mem_be, mem_address and mem_data_in SHALL be registered outputs.

Verification
REQ-021 Write paddr=0x10, pwdata=0xDEADBEEF, pstrb=0xF -> in T1: pready=1, mem_wr=1, mem_address=4, mem_be=0xF, mem_data_in=0xDEADBEEF.
REQ-022 Read paddr=0x10 after REQ-021 -> T1: pready=0, mem_rd=1; T2: pready=1, prdata=0xDEADBEEF, pslverr=0.
REQ-023 Write pwdata=0x0000AA00, pstrb=0x2 to 0x10, then read -> prdata=0xDEADAAEF.
REQ-024 Access paddr=0x400, and separately paddr=0x11 -> T1: pready=1, pslverr=1, prdata=0, no mem_wr/mem_rd pulse.
REQ-025 Back-to-back write 0x20 then read 0x20 with psel held high -> read setup accepted the cycle after the write completes, returned data matches the written data.
REQ-026 rst pulsed during RD_WAIT -> all outputs 0 immediately, no pready; a following read of 0x10 returns the stored value.
